fp_adder_arbiter: RTL and testbench

Shares one 32-bit IEEE-754 Adder between NUM_REQ independent requesters. Each requester presents an operand pair through a valid/ready handshake. The block:
- picks a winner by round-robin,
- drives the Adder's En/A/B,
- waits for the Adder's Ready,
- returns Sum to the winning requester through a valid/ready response channel.

It sits between the requesters and a single Adder instance. At most one operation is in flight.

---
 rtl/fp_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/fp_adder_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_fp_adder_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the round-robin IEEE-754 adder arbiter.
package fp_arb_pkg;

    localparam int WORD_W  = 32;
    localparam int MAX_REQ = 8;
    localparam logic [WORD_W-1:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        RESP      = 3'd4
    } arb_state_t;

    function automatic logic [MAX_REQ-1:0] idx_onehot(input logic [2:0] idx);
        idx_onehot = 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo NUM_REQ. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_req_o
);

    logic found_s;
    int   idx_s;

    assign any_req_o = |req_i;

    // Scan requests in priority order starting at the pointer.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found_s     = 1'b0;
        idx_s       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = (int'(ptr_i) + i) % NUM_REQ;
            if (!found_s && req_i[idx_s]) begin
                found_s        = 1'b1;
                grant_o[idx_s] = 1'b1;
                grant_idx_o    = IDX_W'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one IEEE-754 adder among NUM_REQ requesters, one op in flight.
// Optional Ready timeout enabled by defining FP_ADDER_ARB_TIMEOUT_EN.
module fp_adder_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*WORD_W-1:0] req_a,
    input  logic [NUM_REQ*WORD_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [WORD_W-1:0]         rsp_sum,
    output logic                      rsp_err,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic                      add_en,
    output logic [WORD_W-1:0]         add_a,
    output logic [WORD_W-1:0]         add_b,
    input  logic [WORD_W-1:0]         add_sum,
    input  logic                      add_ready,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [WORD_W-1:0]   add_a_q, add_a_d;
    logic [WORD_W-1:0]   add_b_q, add_b_d;
    logic [WORD_W-1:0]   sum_q, sum_d;
    logic                err_q, err_d;
    logic                add_en_q;
    logic                busy_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;

    logic [NUM_REQ-1:0]  grant_s;
    logic [IDX_W-1:0]    gidx_s;
    logic                any_req_s;
    logic [NUM_REQ-1:0]  req_ready_s;
    logic                tmo_hit_s;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (grant_s),
        .grant_idx_o (gidx_s),
        .any_req_o   (any_req_s)
    );

`ifdef FP_ADDER_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tmo_hit_s = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Wait-cycle counter: cleared while issuing, advances in both wait states.
    always_comb begin
        cnt_d = cnt_q;
        case (state_q)
            ISSUE:     cnt_d = '0;
            WAIT_LOW:  cnt_d = cnt_q + CNT_W'(1);
            WAIT_HIGH: cnt_d = cnt_q + CNT_W'(1);
            default:   cnt_d = cnt_q;
        endcase
    end

    // Wait-cycle counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_tmo_s;

    assign tmo_hit_s    = 1'b0;
    assign unused_tmo_s = (TIMEOUT_CYCLES > 32'sd0);
`endif

    // Next-state, grant and datapath capture.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        sum_d       = sum_q;
        err_d       = err_q;
        req_ready_s = '0;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    req_ready_s = grant_s;
                    gidx_d      = gidx_s;
                    add_a_d     = req_a[WORD_W*int'(gidx_s) +: WORD_W];
                    add_b_d     = req_b[WORD_W*int'(gidx_s) +: WORD_W];
                    state_d     = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT_LOW;
            end
            // A Ready level still high from the previous op must drop before
            // a rising Ready can count as completion.
            WAIT_LOW: begin
                if (tmo_hit_s) begin
                    sum_d   = FP_QNAN;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (!add_ready) begin
                    state_d = WAIT_HIGH;
                end else begin
                    state_d = WAIT_LOW;
                end
            end
            WAIT_HIGH: begin
                if (add_ready) begin
                    sum_d   = add_sum;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tmo_hit_s) begin
                    sum_d   = FP_QNAN;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = WAIT_HIGH;
                end
            end
            RESP: begin
                if (rsp_ready[gidx_q]) begin
                    err_d   = 1'b0;
                    ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer, datapath and registered output flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            sum_q       <= '0;
            err_q       <= 1'b0;
            add_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            sum_q       <= sum_d;
            err_q       <= err_d;
            add_en_q    <= (state_d == ISSUE);
            busy_q      <= (state_d != IDLE);
            rsp_valid_q <= (state_d == RESP) ? NUM_REQ'(idx_onehot(3'(gidx_d))) : '0;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_err   = err_q;
    assign add_en    = add_en_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Scoreboard bench for fp_adder_arbiter: directed operand pairs, adder model
// with configurable latency/stale Ready, monitor checking grants and responses.
module tb_fp_adder_arbiter;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] sum;
        logic        err;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [127:0] req_a, req_b;
    logic [31:0]  rsp_sum, add_a, add_b, add_sum;
    logic         rsp_err, add_en, add_ready, busy;

    int checks = 0;
    int errors = 0;
    int en_count = 0;

    int   grant_q[$];
    exp_t rsp_q[$];

    logic [31:0] op_a [4][16];
    logic [31:0] op_b [4][16];
    int          op_n [4];
    int          op_h [4];
    bit          bp_hold = 1'b0;

    // adder model controls and state
    int          stale_n = 0;
    int          lat_n   = 2;
    bit          stuck   = 1'b0;
    logic        m_ready;
    logic [31:0] m_sum  = 32'h0;
    logic [31:0] m_pend = 32'h0;
    int          m_phase, m_cnt;

    always #5 clk = ~clk;

    fp_adder_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .add_en    (add_en),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .add_ready (add_ready),
        .busy      (busy)
    );

    // Hand-computed IEEE-754 sums for the ordered operand pairs used here.
    function automatic logic [31:0] sum_of(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: sum_of = 32'h40400000;
            {32'h40400000, 32'h40800000}: sum_of = 32'h40E00000;
            {32'h3F000000, 32'h3F000000}: sum_of = 32'h3F800000;
            {32'h41200000, 32'h40A00000}: sum_of = 32'h41700000;
            {32'h3E800000, 32'h3F400000}: sum_of = 32'h3F800000;
            {32'hC0000000, 32'hC0400000}: sum_of = 32'hC0A00000;
            {32'h40000000, 32'h40000000}: sum_of = 32'h40800000;
            default:                      sum_of = 32'hDEADBEEF;
        endcase
    endfunction

    assign add_ready = m_ready;
    assign add_sum   = m_sum;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_ready <= 1'b1;
        end else begin
            case (m_phase)
                0: if (add_en) begin
                    m_pend <= sum_of(add_a, add_b);
                    if (stale_n > 0) begin
                        m_phase <= 1;
                        m_cnt   <= stale_n - 1;
                    end else begin
                        m_ready <= 1'b0;
                        m_phase <= 2;
                        m_cnt   <= lat_n;
                    end
                end
                1: if (m_cnt == 0) begin
                    m_ready <= 1'b0;
                    m_phase <= 2;
                    m_cnt   <= lat_n;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
                2: if (!stuck) begin
                    if (m_cnt == 0) begin
                        m_ready <= 1'b1;
                        m_sum   <= m_pend;
                        m_phase <= 0;
                    end else begin
                        m_cnt <= m_cnt - 1;
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < 4; i++) if (op_h[i] < op_n[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic load(input int r, input logic [31:0] a, input logic [31:0] b);
        op_a[r][op_n[r]] = a;
        op_b[r][op_n[r]] = b;
        op_n[r]++;
    endtask

    task automatic expect_op(input int r, input logic [31:0] s, input logic e);
        exp_t x;
        x.idx = 2'(r);
        x.sum = s;
        x.err = e;
        grant_q.push_back(r);
        rsp_q.push_back(x);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while ((busy || pending() || grant_q.size() != 0 || rsp_q.size() != 0) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) begin
            checks++;
            errors++;
            $display("FAIL %s actual=still_busy_after_%0d_cycles required=idle", name, limit);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_rsp_valid"}, {28'h0, rsp_valid}, 32'h0);
        chk({tag, "_req_ready"}, {28'h0, req_ready}, 32'h0);
        chk({tag, "_add_en"}, {31'h0, add_en}, 32'h0);
        chk({tag, "_add_a"}, add_a, 32'h0);
        chk({tag, "_add_b"}, add_b, 32'h0);
        chk({tag, "_rsp_sum"}, rsp_sum, 32'h0);
        chk({tag, "_rsp_err"}, {31'h0, rsp_err}, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Requester driver: present queued operand pairs, advance on handshake.
    initial begin
        logic [3:0] hs;
        req_valid = 4'h0;
        req_a     = 128'h0;
        req_b     = 128'h0;
        for (int i = 0; i < 4; i++) begin
            op_n[i] = 0;
            op_h[i] = 0;
        end
        forever begin
            @(negedge clk);
            hs = req_ready & req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (hs[i]) op_h[i]++;
                if (op_h[i] < op_n[i]) begin
                    req_valid[i]       = 1'b1;
                    req_a[32*i +: 32]  = op_a[i][op_h[i]];
                    req_b[32*i +: 32]  = op_b[i][op_h[i]];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Response-side ready driver with optional backpressure on requester 1.
    initial begin
        rsp_ready = 4'hF;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = bp_hold ? 4'b1101 : 4'b1111;
        end
    end

    // Monitor: pop the scoreboard on every grant and every accepted response.
    initial begin
        exp_t e;
        int   g;
        logic [3:0] oh;
        forever begin
            @(negedge clk);
            if (add_en) en_count++;
            if (req_ready != 4'h0) begin
                chk("grant_onehot", $countones(req_ready), 32'd1);
                if (grant_q.size() == 0) begin
                    chk("unexpected_grant", {28'h0, req_ready}, 32'h0);
                end else begin
                    g = grant_q.pop_front();
                    chk("grant_idx", idx_of(req_ready), g);
                end
            end
            if ((rsp_valid & rsp_ready) != 4'h0) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", {28'h0, rsp_valid}, 32'h0);
                end else begin
                    e  = rsp_q.pop_front();
                    oh = 4'b0001 << e.idx;
                    chk("rsp_valid", {28'h0, rsp_valid}, {28'h0, oh});
                    chk("rsp_sum", rsp_sum, e.sum);
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=no_finish required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check_zero("post_reset");

        // 1: single requester 0, 1.0 + 2.0
        en_count = 0;
        load(0, 32'h3F800000, 32'h40000000);
        expect_op(0, 32'h40400000, 1'b0);
        wait_idle("t1", 100);
        chk("t1_en_pulses", en_count, 32'd1);
        chk("t1_busy", {31'h0, busy}, 32'h0);
        chk("t1_add_a_hold", add_a, 32'h3F800000);
        chk("t1_add_b_hold", add_b, 32'h40000000);

        // 2: all four at once from pointer 0
        do_reset();
        load(0, 32'h40400000, 32'h40800000);
        load(1, 32'h3F000000, 32'h3F000000);
        load(2, 32'h41200000, 32'h40A00000);
        load(3, 32'h3E800000, 32'h3F400000);
        expect_op(0, 32'h40E00000, 1'b0);
        expect_op(1, 32'h3F800000, 1'b0);
        expect_op(2, 32'h41700000, 1'b0);
        expect_op(3, 32'h3F800000, 1'b0);
        wait_idle("t2", 200);

        // 3: requesters 0 and 2 continuously valid alternate
        for (int k = 0; k < 3; k++) begin
            load(0, 32'h3F800000, 32'h40000000);
            load(2, 32'h3F000000, 32'h3F000000);
        end
        for (int k = 0; k < 3; k++) begin
            expect_op(0, 32'h40400000, 1'b0);
            expect_op(2, 32'h3F800000, 1'b0);
        end
        wait_idle("t3", 300);

        // 4: backpressure on requester 1 with requester 3 waiting
        bp_hold = 1'b1;
        load(1, 32'hC0000000, 32'hC0400000);
        expect_op(1, 32'hC0A00000, 1'b0);
        n = 0;
        while (grant_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        load(3, 32'h3E800000, 32'h3F400000);
        expect_op(3, 32'h3F800000, 1'b0);
        n = 0;
        while (rsp_valid[1] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_rsp_seen", {31'h0, rsp_valid[1]}, 32'h1);
        repeat (10) begin
            @(negedge clk);
            chk("t4_sum_stable", rsp_sum, 32'hC0A00000);
            chk("t4_no_grant", {28'h0, req_ready}, 32'h0);
            chk("t4_valid_held", {28'h0, rsp_valid}, 32'h2);
        end
        bp_hold = 1'b0;
        wait_idle("t4", 100);

        // 5: Ready stays high for two cycles after En
        stale_n = 2;
        load(0, 32'h40000000, 32'h40000000);
        expect_op(0, 32'h40800000, 1'b0);
        wait_idle("t5", 100);
        stale_n = 0;

        // 6: reset while waiting for Ready, then requester 3
        lat_n = 20;
        load(1, 32'h41200000, 32'h40A00000);
        grant_q.push_back(1);
        repeat (10) @(negedge clk);
        chk("t6_busy_before", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        #1;
        check_zero("t6_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        lat_n = 2;
        repeat (30) @(negedge clk);
        chk("t6_no_rsp", {28'h0, rsp_valid}, 32'h0);
        load(3, 32'h40400000, 32'h40800000);
        expect_op(3, 32'h40E00000, 1'b0);
        wait_idle("t6", 100);

`ifdef FP_ADDER_ARB_TIMEOUT_EN
        // timeout: Ready never returns
        stuck = 1'b1;
        load(0, 32'h40400000, 32'h40800000);
        expect_op(0, 32'h7FC00000, 1'b1);
        wait_idle("tmo", 300);
        chk("tmo_err_clear", {31'h0, rsp_err}, 32'h0);
        stuck = 1'b0;
        do_reset();
`endif

        repeat (5) @(negedge clk);
        chk("final_grant_q", grant_q.size(), 32'd0);
        chk("final_rsp_q", rsp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
